// File: rtl/enc64b66b_pkg.sv
// Shared constants and types for the 64b/66b transmit encoder.
// Build option ENCODE_ERR_CNT_EN (see encode_64b_66b) does not affect this package.
package enc64b66b_pkg;

  // XGMII control characters
  localparam logic [7:0] XG_IDLE  = 8'h07;
  localparam logic [7:0] XG_START = 8'hFB;
  localparam logic [7:0] XG_TERM  = 8'hFD;
  localparam logic [7:0] XG_ERROR = 8'hFE;

  // Block type field values
  localparam logic [7:0] BT_IDLE = 8'h1E;
  localparam logic [7:0] BT_S0   = 8'h78;
  localparam logic [7:0] BT_S4   = 8'h33;
  localparam logic [7:0] BT_T0   = 8'h87;
  localparam logic [7:0] BT_T1   = 8'h99;
  localparam logic [7:0] BT_T2   = 8'hAA;
  localparam logic [7:0] BT_T3   = 8'hB4;
  localparam logic [7:0] BT_T4   = 8'hCC;
  localparam logic [7:0] BT_T5   = 8'hD2;
  localparam logic [7:0] BT_T6   = 8'hE1;
  localparam logic [7:0] BT_T7   = 8'hFF;

  // Sync headers
  localparam logic [1:0] HDR_DATA = 2'b10;
  localparam logic [1:0] HDR_CTRL = 2'b01;

  // Control block carrying eight /E/ (7'h1E) control codes
  localparam logic [63:0] ERROR_BLOCK = {{8{7'h1E}}, BT_IDLE};

  typedef enum logic [1:0] {
    ST_INIT,
    ST_C,
    ST_D,
    ST_E
  } tx_state_e;

  typedef enum logic [2:0] {
    CLS_C,
    CLS_S,
    CLS_D,
    CLS_T,
    CLS_E
  } blk_class_e;

  // Block type for a terminate in lane k
  function automatic logic [7:0] term_type(input logic [2:0] k);
    case (k)
      3'd0:    term_type = BT_T0;
      3'd1:    term_type = BT_T1;
      3'd2:    term_type = BT_T2;
      3'd3:    term_type = BT_T3;
      3'd4:    term_type = BT_T4;
      3'd5:    term_type = BT_T5;
      3'd6:    term_type = BT_T6;
      default: term_type = BT_T7;
    endcase
  endfunction

endpackage

// File: rtl/encode_classify.sv
// Combinational classifier: maps one XGMII word to a block class and
// its formatted 64-bit block payload (type byte in [7:0]).
module encode_classify
  import enc64b66b_pkg::*;
(
  input  logic [63:0] txd_i,
  input  logic [7:0]  txc_i,
  output blk_class_e  cls_o,
  output logic [63:0] payload_o
);

  logic [7:0] idle_lane;

  always_comb begin
    for (int j = 0; j < 8; j++) begin
      idle_lane[j] = (txd_i[8*j +: 8] == XG_IDLE);
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    cls_o     = CLS_E;
    payload_o = ERROR_BLOCK;

    if (txc_i == 8'h00) begin
      cls_o     = CLS_D;
      payload_o = txd_i;
    end else if (txc_i == 8'hFF && (&idle_lane)) begin
      cls_o     = CLS_C;
      payload_o = {56'h0, BT_IDLE};
    end else if (txc_i == 8'h01 && txd_i[7:0] == XG_START) begin
      cls_o     = CLS_S;
      payload_o = {txd_i[63:8], BT_S0};
    end else if (txc_i == 8'h1F && (&idle_lane[3:0]) && txd_i[39:32] == XG_START) begin
      cls_o     = CLS_S;
      payload_o = {txd_i[63:40], 32'h0, BT_S4};
    end else begin
      // Terminate in lane k: control bits k..7, idles above k, data below k
      for (int k = 0; k < 8; k++) begin
        if (txc_i == (8'hFF << k) && txd_i[8*k +: 8] == XG_TERM &&
            (idle_lane | ~(8'hFE << k)) == 8'hFF) begin
          cls_o     = CLS_T;
          payload_o = {56'h0, term_type(3'(k))};
          for (int j = 0; j < 7; j++) begin
            if (j < k) payload_o[8*j+8 +: 8] = txd_i[8*j +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/encode_64b_66b.sv
// 64b/66b TX encoder: stage 1 registers the classified word, stage 2 runs the
// frame-sequencing FSM. Define ENCODE_ERR_CNT_EN to add a saturating error-block counter.
module encode_64b_66b
  import enc64b66b_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] xgmii_txd_i,
  input  logic [7:0]  xgmii_txc_i,
  input  logic        xgmii_txd_vld_i,
  output logic [63:0] encode_data_o,
  output logic [1:0]  encode_head_o,
  output logic        encode_data_vld_o,
  output logic        encode_error_o
`ifdef ENCODE_ERR_CNT_EN
  ,
  output logic [15:0] encode_err_cnt_o
`endif
);

  blk_class_e  cls;
  logic [63:0] payload;

  encode_classify u_classify (
    .txd_i     (xgmii_txd_i),
    .txc_i     (xgmii_txc_i),
    .cls_o     (cls),
    .payload_o (payload)
  );

  // Stage 1: classified word
  logic        s1_vld_q;
  blk_class_e  s1_cls_q;
  logic [63:0] s1_data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_vld_q  <= 1'b0;
      s1_cls_q  <= CLS_E;
      s1_data_q <= 64'h0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so stage 2 sees
      // the word registered on the previous edge, not this one.
      s1_vld_q <= xgmii_txd_vld_i;
      if (xgmii_txd_vld_i) begin
        s1_cls_q  <= cls;
        s1_data_q <= payload;
      end
    end
  end

  // Stage 2: sequencing FSM
  tx_state_e   state_q, state_d;
  logic        blk_err;
  logic [63:0] data_q;
  logic [1:0]  head_q;
  logic        vld_q;
  logic        err_q;

  always_comb begin
    state_d = ST_E;
    case (s1_cls_q)
      CLS_C:   state_d = (state_q == ST_D) ? ST_E : ST_C;
      CLS_S:   state_d = (state_q == ST_D) ? ST_E : ST_D;
      CLS_D:   state_d = (state_q == ST_D || state_q == ST_E) ? ST_D : ST_E;
      CLS_T:   state_d = (state_q == ST_D || state_q == ST_E) ? ST_C : ST_E;
      default: state_d = ST_E;
    endcase
  end

  // Any move into (or staying in) E replaces the block with an error block
  assign blk_err = (state_d == ST_E);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
      data_q  <= 64'h0;
      head_q  <= 2'b00;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        state_q <= state_d;
        err_q   <= blk_err;
        if (blk_err) begin
          data_q <= ERROR_BLOCK;
          head_q <= HDR_CTRL;
        end else begin
          data_q <= s1_data_q;
          head_q <= (s1_cls_q == CLS_D) ? HDR_DATA : HDR_CTRL;
        end
      end
    end
  end

  assign encode_data_o     = data_q;
  assign encode_head_o     = head_q;
  assign encode_data_vld_o = vld_q;
  assign encode_error_o    = err_q;

`ifdef ENCODE_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_q <= 16'h0;
    end else if (s1_vld_q && blk_err && err_cnt_q != 16'hFFFF) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign encode_err_cnt_o = err_cnt_q;
`endif

endmodule

// File: doc/encode_64b_66b.md
# encode_64b_66b

Transmit-side 64b/66b encoder: converts one 64-bit XGMII TX word plus 8-bit control mask into a 2-bit sync header and 64-bit block payload for the GTX TX gearbox. Sits between the MAC XGMII TX interface and the transceiver, clocked at 156.25×2 MHz with a valid qualifier. A TX state machine enforces legal frame sequencing; illegal sequences are replaced by error blocks and flagged.

## Interface
Parameters: none.

Ports:
- clk_i  in  1  transceiver-side clock (156.25×2 MHz)
- rst_i  in  1  reset; asynchronous, active-high
- xgmii_txd_i  in  64  XGMII TX data, lane 0 = [7:0]
- xgmii_txc_i  in  8  XGMII TX control mask, bit n = lane n
- xgmii_txd_vld_i  in  1  input word valid
- encode_data_o  out  64  block payload, block type field = [7:0]
- encode_head_o  out  2  sync header: 2'b10 data, 2'b01 control
- encode_data_vld_o  out  1  output block valid
- encode_error_o  out  1  high with any output block that is an error block

## Operation
- Classify each valid word (stage 1):
  - D: txc = 8'h00 -> head 10, payload = txd.
  - C (idle): txc = 8'hFF, all lanes 8'h07 -> type 8'h1E, [63:8] = 0.
  - S0: txc = 8'h01, lane0 = 8'hFB -> type 8'h78, payload {txd[63:8], 8'h78}.
  - S4: txc = 8'h1F, lanes0-3 = 8'h07, lane4 = 8'hFB -> type 8'h33, payload {txd[63:40], 32'h0, 8'h33}.
  - Tk (k = 0..7): txc bits k..7 set, bits below k clear, lane k = 8'hFD, lanes above k = 8'h07 -> type 87/99/AA/B4/CC/D2/E1/FF for k = 0..7; data lanes 0..k-1 in [8k+7:8]; remaining bits 0.
  - E: anything else.
- Error block: head 01, type 8'h1E, eight 7-bit fields each 7'h1E in [63:8].
- State machine (stage 2), states INIT, C, D, E:
  - INIT, C: C->C, S->D, D/T/E->E.
  - D: D->D, T->C, C/S/E->E.
  - E: C->C, S->D, D->D, T->C, E->E.
  - Transition into E: emit error block, assert encode_error_o. All other transitions: emit classified block.
- State advances only on valid input; invalid cycles hold state and pipeline contents.

## Timing
- Latency 2 clk_i cycles, valid input to valid output; encode_data_vld_o is xgmii_txd_vld_i delayed 2 cycles.
- encode_error_o aligned with its block, cleared on every non-error valid output.
- Reset values: encode_data_o 64'h0, encode_head_o 2'b00, encode_data_vld_o 0, encode_error_o 0, state INIT, pipeline valid bits 0.
- Reset mid-frame: state returns to INIT; the next S is accepted, and a D or T before an S produces an error block.
- Back-to-back T then S accepted (IPG not checked).

## Configuration
- ENCODE_ERR_CNT_EN defined: extra port encode_err_cnt_o out 16, counts error blocks emitted, saturates at 16'hFFFF, reset 0.
- Not defined: no port, no counter logic.

## Structure
- Package enc64b66b_pkg: block-type constants (1E, 78, 33, 87..FF), XGMII characters (07, FB, FD, FE), header constants, state enum, block-class enum.
- Sub-module encode_classify: combinational per-word classifier returning class and formatted payload. The top module holds the pipeline registers and the state machine.

## Test plan
- After reset, idle words (txc FF, txd 0707…07) -> head 01, payload 56'h0 & 8'h1E, error 0.
- S0 frame {txd 0xD5555555_555555FB, txc 01}, 2 D words, T3 -> blocks 78, 10/10 data, B4 with data lanes 0-2 in [31:8], each 2 cycles after its input.
- S4 word {lanes 5-7 data, lane4 FB, lanes0-3 07, txc 1F} -> type 33, [63:40] = txd[63:40], [39:8] = 0.
- D word directly after idle -> error block (fields 7'h1E), encode_error_o 1; the next S is accepted and error returns to 0.
- Valid deasserted for 3 cycles mid-frame -> no output valids, state held, frame resumes without error.
- With ENCODE_ERR_CNT_EN: 3 illegal D-after-C words -> encode_err_cnt_o = 3; async reset mid-frame -> outputs zero immediately, counter 0, next T -> error block.
